// File: rtl/sup_count_checker_if.sv
// Bundle between the Lab 1 up-counter side and its checker: the sampled counter value,
// the counter's reset and clear inputs, and the checker's status outputs.
interface sup_count_checker_if #(
    parameter int WIDTH = 4,
    parameter int ERRW  = 8,
    parameter int WRAPW = 8
);
    logic [WIDTH-1:0] Q;
    logic             cnt_rst_n;
    logic             clr;
    logic [1:0]       state;
    logic             locked;
    logic             step;
    logic             err;
    logic [ERRW-1:0]  err_count;
    logic [WRAPW-1:0] wraps;
    logic [WIDTH-1:0] first_bad;

    modport master (
        output Q, cnt_rst_n, clr,
        input  state, locked, step, err, err_count, wraps, first_bad
    );

    modport slave (
        input  Q, cnt_rst_n, clr,
        output state, locked, step, err, err_count, wraps, first_bad
    );
endinterface

// File: rtl/sup_count_checker.sv
// Monitors a free-running up-counter and flags any edge where Q neither holds nor
// advances by exactly one (mod 2^WIDTH); keeps sticky error status and a wrap count.
module sup_count_checker #(
    parameter int WIDTH = 4,
    parameter int ERRW  = 8,
    parameter int WRAPW = 8
) (
    input logic Clock,
    input logic Reset,
    sup_count_checker_if.slave bus
);
    typedef enum logic [1:0] {
        ACQ   = 2'b00,
        TRACK = 2'b01,
        ERR   = 2'b10
    } state_t;

    localparam logic [WIDTH-1:0] ONE_W   = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] MAX_W   = {WIDTH{1'b1}};
    localparam logic [ERRW-1:0]  ONE_E   = {{(ERRW-1){1'b0}}, 1'b1};
    localparam logic [ERRW-1:0]  MAX_E   = {ERRW{1'b1}};
    localparam logic [WRAPW-1:0] ONE_R   = {{(WRAPW-1){1'b0}}, 1'b1};

    state_t           state_q;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] nxt;
    logic             locked_q;
    logic             step_q;
    logic             err_q;
    logic [ERRW-1:0]  err_count_q;
    logic [WRAPW-1:0] wraps_q;
    logic [WIDTH-1:0] first_bad_q;

    assign nxt = prev + ONE_W;

    // Counter reset and clear both force reacquisition; clear additionally wipes the
    // error record, while a counter reset alone must leave the evidence intact.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q     <= ACQ;
            prev        <= '0;
            locked_q    <= 1'b0;
            step_q      <= 1'b0;
            err_q       <= 1'b0;
            err_count_q <= '0;
            wraps_q     <= '0;
            first_bad_q <= '0;
        end else if (!bus.cnt_rst_n || bus.clr) begin
            state_q  <= ACQ;
            locked_q <= 1'b0;
            step_q   <= 1'b0;
            if (bus.clr) begin
                err_q       <= 1'b0;
                err_count_q <= '0;
                first_bad_q <= '0;
            end
        end else begin
            case (state_q)
                ACQ: begin
                    prev     <= bus.Q;
                    step_q   <= 1'b0;
                    locked_q <= 1'b1;
                    state_q  <= TRACK;
                end
                TRACK, ERR: begin
                    locked_q <= 1'b1;
                    if (bus.Q == prev) begin
                        step_q <= 1'b0;
                    end else if (bus.Q == nxt) begin
                        step_q <= 1'b1;
                        prev   <= bus.Q;
                        if (prev == MAX_W) begin
                            wraps_q <= wraps_q + ONE_R;
                        end
                    end else begin
                        // Resync on the bad value so one glitch counts as one error.
                        step_q  <= 1'b0;
                        prev    <= bus.Q;
                        err_q   <= 1'b1;
                        state_q <= ERR;
                        if (err_count_q != MAX_E) begin
                            err_count_q <= err_count_q + ONE_E;
                        end
                        if (!err_q) begin
                            first_bad_q <= bus.Q;
                        end
                    end
                end
                default: begin
                    state_q  <= ACQ;
                    locked_q <= 1'b0;
                    step_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.state     = state_q;
    assign bus.locked    = locked_q;
    assign bus.step      = step_q;
    assign bus.err       = err_q;
    assign bus.err_count = err_count_q;
    assign bus.wraps     = wraps_q;
    assign bus.first_bad = first_bad_q;
endmodule

// File: tb/tb_sup_count_checker.sv
// Directed bench for sup_count_checker: counting, wrap, illegal jumps, saturation,
// counter reset, clear and asynchronous reset, each against hand-computed values.
module tb_sup_count_checker;
    logic Clock;
    logic Reset;
    int   checkCount;
    int   failCount;
    int   stepCount;

    sup_count_checker_if #(.WIDTH(4), .ERRW(8), .WRAPW(8)) bus ();

    sup_count_checker #(.WIDTH(4), .ERRW(8), .WRAPW(8)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Inputs change 1 time unit after an edge, results are sampled 1 unit after the next.
    task automatic applyStimulus(input logic [3:0] q, input logic cntRstN, input logic clear);
        bus.Q         = q;
        bus.cnt_rst_n = cntRstN;
        bus.clr       = clear;
        @(posedge Clock);
        #1;
    endtask

    initial begin
        checkCount = 0;
        failCount  = 0;
        stepCount  = 0;
        Reset         = 1'b0;
        bus.Q         = 4'd0;
        bus.cnt_rst_n = 1'b1;
        bus.clr       = 1'b0;

        repeat (2) @(posedge Clock);
        #1;
        checkOutput("reset state", 32'(bus.state), 32'd0);
        checkOutput("reset locked", 32'(bus.locked), 32'd0);
        checkOutput("reset err_count", 32'(bus.err_count), 32'd0);
        Reset = 1'b1;

        // Hold Q=0: acquire then track without stepping
        applyStimulus(4'd0, 1'b1, 1'b0);
        checkOutput("acq->track state", 32'(bus.state), 32'd1);
        checkOutput("acq->track locked", 32'(bus.locked), 32'd1);
        applyStimulus(4'd0, 1'b1, 1'b0);
        applyStimulus(4'd0, 1'b1, 1'b0);
        checkOutput("hold step", 32'(bus.step), 32'd0);
        checkOutput("hold err", 32'(bus.err), 32'd0);

        // Count 1..15, 0, 1
        for (int v = 1; v <= 15; v++) begin
            applyStimulus(4'(v), 1'b1, 1'b0);
            if (bus.step) stepCount++;
        end
        checkOutput("wraps before wrap", 32'(bus.wraps), 32'd0);
        applyStimulus(4'd0, 1'b1, 1'b0);
        if (bus.step) stepCount++;
        checkOutput("wraps after wrap", 32'(bus.wraps), 32'd1);
        applyStimulus(4'd1, 1'b1, 1'b0);
        if (bus.step) stepCount++;
        checkOutput("step pulses", 32'(stepCount), 32'd17);
        checkOutput("count err", 32'(bus.err), 32'd0);

        // prev=5 then illegal 9, then legal 10
        for (int v = 2; v <= 5; v++) applyStimulus(4'(v), 1'b1, 1'b0);
        applyStimulus(4'd9, 1'b1, 1'b0);
        checkOutput("jump err", 32'(bus.err), 32'd1);
        checkOutput("jump err_count", 32'(bus.err_count), 32'd1);
        checkOutput("jump first_bad", 32'(bus.first_bad), 32'd9);
        checkOutput("jump state", 32'(bus.state), 32'd2);
        checkOutput("jump step", 32'(bus.step), 32'd0);
        applyStimulus(4'd10, 1'b1, 1'b0);
        checkOutput("resync step", 32'(bus.step), 32'd1);
        checkOutput("resync err_count", 32'(bus.err_count), 32'd1);
        checkOutput("resync state", 32'(bus.state), 32'd2);

        // Clear, reacquire at 0, then 300 alternating 8/0 jumps
        applyStimulus(4'd10, 1'b1, 1'b1);
        checkOutput("clr state", 32'(bus.state), 32'd0);
        checkOutput("clr err", 32'(bus.err), 32'd0);
        checkOutput("clr err_count", 32'(bus.err_count), 32'd0);
        checkOutput("clr first_bad", 32'(bus.first_bad), 32'd0);
        checkOutput("clr locked", 32'(bus.locked), 32'd0);
        checkOutput("clr keeps wraps", 32'(bus.wraps), 32'd1);
        applyStimulus(4'd0, 1'b1, 1'b0);
        for (int i = 0; i < 300; i++) begin
            applyStimulus((i % 2 == 0) ? 4'd8 : 4'd0, 1'b1, 1'b0);
            if (i == 254) checkOutput("err_count at 255", 32'(bus.err_count), 32'd255);
        end
        checkOutput("saturated err_count", 32'(bus.err_count), 32'd255);
        checkOutput("saturated first_bad", 32'(bus.first_bad), 32'd8);
        checkOutput("saturated state", 32'(bus.state), 32'd2);

        // Counter reset from 7 with no error pending
        applyStimulus(4'd7, 1'b1, 1'b1);
        applyStimulus(4'd7, 1'b1, 1'b0);
        checkOutput("track at 7", 32'(bus.state), 32'd1);
        applyStimulus(4'd0, 1'b0, 1'b0);
        checkOutput("cnt_rst state", 32'(bus.state), 32'd0);
        checkOutput("cnt_rst locked", 32'(bus.locked), 32'd0);
        applyStimulus(4'd0, 1'b1, 1'b0);
        checkOutput("cnt_rst reacq", 32'(bus.state), 32'd1);
        applyStimulus(4'd1, 1'b1, 1'b0);
        checkOutput("cnt_rst step", 32'(bus.step), 32'd1);
        checkOutput("cnt_rst err", 32'(bus.err), 32'd0);

        // Counter reset with an error pending keeps the error record
        applyStimulus(4'd5, 1'b1, 1'b0);
        checkOutput("second err first_bad", 32'(bus.first_bad), 32'd5);
        applyStimulus(4'd6, 1'b1, 1'b0);
        applyStimulus(4'd7, 1'b1, 1'b0);
        applyStimulus(4'd0, 1'b0, 1'b0);
        checkOutput("cnt_rst err kept", 32'(bus.err), 32'd1);
        checkOutput("cnt_rst err_count kept", 32'(bus.err_count), 32'd1);
        checkOutput("cnt_rst state err", 32'(bus.state), 32'd0);
        applyStimulus(4'd0, 1'b1, 1'b0);
        applyStimulus(4'd1, 1'b1, 1'b0);
        checkOutput("post cnt_rst state", 32'(bus.state), 32'd1);
        checkOutput("post cnt_rst step", 32'(bus.step), 32'd1);
        checkOutput("post cnt_rst err", 32'(bus.err), 32'd1);

        // Clear wins over an illegal value on the same edge
        applyStimulus(4'd9, 1'b1, 1'b1);
        checkOutput("clr+jump err", 32'(bus.err), 32'd0);
        checkOutput("clr+jump err_count", 32'(bus.err_count), 32'd0);
        checkOutput("clr+jump state", 32'(bus.state), 32'd0);

        // Build up status, then assert Reset between edges
        applyStimulus(4'd9, 1'b1, 1'b0);
        applyStimulus(4'd3, 1'b1, 1'b0);
        checkOutput("pre-reset err", 32'(bus.err), 32'd1);
        applyStimulus(4'd4, 1'b1, 1'b0);
        checkOutput("pre-reset step", 32'(bus.step), 32'd1);
        #2;
        Reset = 1'b0;
        #1;
        checkOutput("async state", 32'(bus.state), 32'd0);
        checkOutput("async locked", 32'(bus.locked), 32'd0);
        checkOutput("async step", 32'(bus.step), 32'd0);
        checkOutput("async err", 32'(bus.err), 32'd0);
        checkOutput("async err_count", 32'(bus.err_count), 32'd0);
        checkOutput("async wraps", 32'(bus.wraps), 32'd0);
        checkOutput("async first_bad", 32'(bus.first_bad), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end
endmodule
